// File: rtl/digger_pkg.sv
// Shared definitions for the collision controller.
//   GOLD_*          : 4-bit gold-bag state codes as carried on gold_state
//   player_state_e  : player life-cycle FSM states
package digger_pkg;

    localparam logic [3:0] GOLD_RESTING = 4'd0;
    localparam logic [3:0] GOLD_FALLING = 4'd2;
    localparam logic [3:0] GOLD_BROKEN  = 4'd3;

    typedef enum logic {
        StAlive,
        StInvuln
    } player_state_e;

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame event flag with a one-cycle evaluation pulse.
//   clk          : pixel clock
//   resetN       : synchronous active-low reset
//   startOfFrame : evaluation strobe; pulse follows one cycle later
//   hit          : per-pixel event, OR-accumulated over the frame
//   pulse        : high for the cycle after startOfFrame if any hit was seen
module frame_event_latch
    import digger_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit,
    output logic pulse
);

    logic flag_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else if (startOfFrame) begin
            pulse_q <= flag_q;
            // A hit on the start-of-frame pixel belongs to the new frame.
            flag_q  <= hit;
        end else begin
            pulse_q <= 1'b0;
            flag_q  <= flag_q | hit;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_collision_ctrl.sv
// Per-pixel collision detection, frame-latched event pulses and the player
// death / invulnerability FSM.
//   startOfFrame            : evaluation strobe at pixel (0,0)
//   player_awake            : gates deadly collisions
//   drawing_request_*/shot_dr/alien_dr/gold_dr : per-pixel draw requests
//   gold_state              : packed 4-bit gold states
//   collision_player_terrain: registered player/terrain overlap
//   colision_fire           : shot hit terrain or any alien this frame
//   alien_died              : per-alien kill pulse
//   collision_gold          : level, player pushed resting gold last frame
//   player_eat_gold         : per-gold collect pulse
//   player_died             : death pulse
//   invulnerable            : post-death grace period
module game_collision_ctrl
    import digger_pkg::*;
#(
    parameter int unsigned NUM_ALIENS    = 4,
    parameter int unsigned NUM_GOLD      = 4,
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  player_awake,
    input  logic                  drawing_request_player,
    input  logic                  drawing_request_terrain,
    input  logic                  shot_dr,
    input  logic [NUM_ALIENS-1:0] alien_dr,
    input  logic [NUM_GOLD-1:0]   gold_dr,
    input  logic [4*NUM_GOLD-1:0] gold_state,
    output logic                  collision_player_terrain,
    output logic                  colision_fire,
    output logic [NUM_ALIENS-1:0] alien_died,
    output logic [NUM_GOLD-1:0]   collision_gold,
    output logic [NUM_GOLD-1:0]   player_eat_gold,
    output logic                  player_died,
    output logic                  invulnerable
);

    logic [NUM_ALIENS-1:0] shot_alien_hit;
    logic [NUM_ALIENS-1:0] player_alien_hit;
    logic [NUM_ALIENS-1:0] player_alien_pulse;
    logic [NUM_GOLD-1:0]   eat_hit;
    logic [NUM_GOLD-1:0]   fall_hit;
    logic [NUM_GOLD-1:0]   fall_pulse;
    logic [NUM_GOLD-1:0]   rest_hit;
    logic                  fire_hit;
    logic                  kill_any;

    // Deadly overlaps only count while the player is controllable.
    assign shot_alien_hit   = shot_dr ? alien_dr : '0;
    assign player_alien_hit = (drawing_request_player && player_awake) ? alien_dr : '0;
    assign fire_hit         = shot_dr && (drawing_request_terrain || (|alien_dr));

    frame_event_latch u_fire_latch (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .hit          (fire_hit),
        .pulse        (colision_fire)
    );

    for (genvar i = 0; i < NUM_ALIENS; i++) begin : g_alien
        frame_event_latch u_shot_alien (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .hit          (shot_alien_hit[i]),
            .pulse        (alien_died[i])
        );
        frame_event_latch u_player_alien (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .hit          (player_alien_hit[i]),
            .pulse        (player_alien_pulse[i])
        );
    end

    for (genvar i = 0; i < NUM_GOLD; i++) begin : g_gold
        logic [3:0] gs;
        logic       touch;
        assign gs          = gold_state[4*i +: 4];
        assign touch       = drawing_request_player && gold_dr[i];
        assign eat_hit[i]  = touch && (gs == GOLD_BROKEN);
        assign fall_hit[i] = touch && player_awake && (gs == GOLD_FALLING);
        assign rest_hit[i] = touch && (gs == GOLD_RESTING);

        frame_event_latch u_eat (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .hit          (eat_hit[i]),
            .pulse        (player_eat_gold[i])
        );
        frame_event_latch u_fall (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .hit          (fall_hit[i]),
            .pulse        (fall_pulse[i])
        );
    end

    // Resting-gold push is a level held for a whole frame, so it keeps its own
    // sticky flag and loads the level at each evaluation.
    logic [NUM_GOLD-1:0] rest_flag_q;
    logic [NUM_GOLD-1:0] rest_level_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rest_flag_q  <= '0;
            rest_level_q <= '0;
        end else if (startOfFrame) begin
            rest_level_q <= rest_flag_q;
            rest_flag_q  <= rest_hit;
        end else begin
            rest_flag_q  <= rest_flag_q | rest_hit;
        end
    end

    assign collision_gold = rest_level_q;

    logic cpt_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cpt_q <= 1'b0;
        end else begin
            cpt_q <= drawing_request_player && drawing_request_terrain;
        end
    end

    assign collision_player_terrain = cpt_q;

    // Player FSM. Whether the player may die is decided by the state at the
    // evaluation cycle, so the last invulnerable frame cannot leak a death.
    player_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          alive_eval_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= StAlive;
            cnt_q        <= 8'd0;
            alive_eval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (startOfFrame) begin
                alive_eval_q <= (state_q == StAlive);
            end
        end
    end

    // A shot alien never kills, even if it touched the player the same frame.
    assign kill_any    = (|(player_alien_pulse & ~alien_died)) || (|fall_pulse);
    assign player_died = kill_any && alive_eval_q && (state_q == StAlive);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAlive: begin
                if (player_died) begin
                    state_d = StInvuln;
                    cnt_d   = 8'(INVULN_FRAMES);
                end
            end
            StInvuln: begin
                if (startOfFrame) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = StAlive;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StAlive;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign invulnerable = (state_q == StInvuln);

endmodule

// File: tb/tb_game_collision_ctrl.sv
// Directed bench for game_collision_ctrl with default parameters.
module tb_game_collision_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        player_awake;
    logic        drawing_request_player;
    logic        drawing_request_terrain;
    logic        shot_dr;
    logic [3:0]  alien_dr;
    logic [3:0]  gold_dr;
    logic [15:0] gold_state;
    logic        collision_player_terrain;
    logic        colision_fire;
    logic [3:0]  alien_died;
    logic [3:0]  collision_gold;
    logic [3:0]  player_eat_gold;
    logic        player_died;
    logic        invulnerable;

    int checks   = 0;
    int failures = 0;

    game_collision_ctrl dut (
        .clk                      (clk),
        .resetN                   (resetN),
        .startOfFrame             (startOfFrame),
        .player_awake             (player_awake),
        .drawing_request_player   (drawing_request_player),
        .drawing_request_terrain  (drawing_request_terrain),
        .shot_dr                  (shot_dr),
        .alien_dr                 (alien_dr),
        .gold_dr                  (gold_dr),
        .gold_state               (gold_state),
        .collision_player_terrain (collision_player_terrain),
        .colision_fire            (colision_fire),
        .alien_died               (alien_died),
        .collision_gold           (collision_gold),
        .player_eat_gold          (player_eat_gold),
        .player_died              (player_died),
        .invulnerable             (invulnerable)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_overlaps();
        drawing_request_player  = 1'b0;
        drawing_request_terrain = 1'b0;
        shot_dr                 = 1'b0;
        alien_dr                = 4'd0;
        gold_dr                 = 4'd0;
    endtask

    task automatic do_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cpt"},  32'(collision_player_terrain), 32'd0);
        chk({tag, ".fire"}, 32'(colision_fire),            32'd0);
        chk({tag, ".died"}, 32'(alien_died),               32'd0);
        chk({tag, ".cg"},   32'(collision_gold),           32'd0);
        chk({tag, ".eat"},  32'(player_eat_gold),          32'd0);
        chk({tag, ".pd"},   32'(player_died),              32'd0);
        chk({tag, ".inv"},  32'(invulnerable),             32'd0);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        player_awake = 1'b0;
        gold_state   = 16'h0000;
        clear_overlaps();
        ticks(2);
        chk_all_zero("reset");
        resetN = 1'b1;
        tick();

        // Overlap on the start-of-frame pixel belongs to the new frame.
        shot_dr      = 1'b1;
        alien_dr     = 4'b0001;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        clear_overlaps();
        chk("sofpix_old_frame", 32'(alien_died), 32'd0);
        ticks(3);
        do_sof();
        chk("sofpix_new_frame", 32'(alien_died), 32'b0001);
        tick();

        // Shot on alien 2 for 30 pixels.
        shot_dr  = 1'b1;
        alien_dr = 4'b0100;
        ticks(30);
        clear_overlaps();
        tick();
        do_sof();
        chk("a2_died",  32'(alien_died),      32'b0100);
        chk("a2_fire",  32'(colision_fire),   32'd1);
        chk("a2_pd",    32'(player_died),     32'd0);
        chk("a2_eat",   32'(player_eat_gold), 32'd0);
        tick();
        chk("a2_died_end", 32'(alien_died),    32'd0);
        chk("a2_fire_end", 32'(colision_fire), 32'd0);

        // Shot hits terrain and alien 0 in one frame: one fire pulse.
        shot_dr                 = 1'b1;
        drawing_request_terrain = 1'b1;
        ticks(2);
        drawing_request_terrain = 1'b0;
        alien_dr                = 4'b0001;
        ticks(2);
        clear_overlaps();
        do_sof();
        chk("ta_fire", 32'(colision_fire), 32'd1);
        chk("ta_died", 32'(alien_died),    32'b0001);
        tick();
        chk("ta_fire_once", 32'(colision_fire), 32'd0);

        // Player/terrain registered overlap.
        drawing_request_player  = 1'b1;
        drawing_request_terrain = 1'b1;
        tick();
        chk("cpt_hi", 32'(collision_player_terrain), 32'd1);
        clear_overlaps();
        tick();
        chk("cpt_lo", 32'(collision_player_terrain), 32'd0);

        // Player and shot both on alien 3: alien dies, player survives.
        player_awake           = 1'b1;
        drawing_request_player = 1'b1;
        shot_dr                = 1'b1;
        alien_dr               = 4'b1000;
        ticks(3);
        clear_overlaps();
        do_sof();
        chk("a3_died", 32'(alien_died),  32'b1000);
        chk("a3_pd",   32'(player_died), 32'd0);
        tick();

        // Asleep player touching an alien does not die.
        player_awake           = 1'b0;
        drawing_request_player = 1'b1;
        alien_dr               = 4'b0001;
        ticks(4);
        clear_overlaps();
        do_sof();
        chk("sleep_pd", 32'(player_died), 32'd0);
        tick();
        chk("sleep_inv", 32'(invulnerable), 32'd0);

        // Broken gold 1 is eaten.
        player_awake           = 1'b1;
        drawing_request_player = 1'b1;
        gold_dr                = 4'b0010;
        gold_state             = 16'h0030;
        ticks(3);
        clear_overlaps();
        do_sof();
        chk("eat_pulse", 32'(player_eat_gold), 32'b0010);
        chk("eat_pd",    32'(player_died),     32'd0);
        tick();
        chk("eat_end",   32'(player_eat_gold), 32'd0);

        // Resting gold 1: level held for one frame.
        gold_state             = 16'h0000;
        drawing_request_player = 1'b1;
        gold_dr                = 4'b0010;
        ticks(3);
        clear_overlaps();
        do_sof();
        chk("rest_lvl0", 32'(collision_gold), 32'b0010);
        ticks(5);
        chk("rest_lvl1", 32'(collision_gold), 32'b0010);
        do_sof();
        chk("rest_off",  32'(collision_gold), 32'd0);

        // Two aliens kill the player once, then 60 invulnerable frames.
        drawing_request_player = 1'b1;
        alien_dr               = 4'b0011;
        ticks(4);
        clear_overlaps();
        do_sof();
        chk("kill_pd", 32'(player_died), 32'd1);
        tick();
        chk("kill_pd_once", 32'(player_died),  32'd0);
        chk("kill_inv",     32'(invulnerable), 32'd1);
        for (int k = 1; k <= 60; k++) begin
            drawing_request_player = 1'b1;
            alien_dr               = 4'b0001;
            ticks(2);
            clear_overlaps();
            chk($sformatf("inv_f%0d", k), 32'(invulnerable), 32'd1);
            do_sof();
            chk($sformatf("inv_pd_f%0d", k), 32'(player_died), 32'd0);
            tick();
        end
        chk("inv_over", 32'(invulnerable), 32'd0);
        drawing_request_player = 1'b1;
        alien_dr               = 4'b0001;
        ticks(2);
        clear_overlaps();
        do_sof();
        chk("f61_pd", 32'(player_died), 32'd1);
        tick();
        chk("f61_inv", 32'(invulnerable), 32'd1);

        // Reset mid-frame and mid-INVULN discards the partial frame.
        shot_dr  = 1'b1;
        alien_dr = 4'b0100;
        ticks(5);
        clear_overlaps();
        resetN = 1'b0;
        tick();
        chk_all_zero("midrst");
        resetN = 1'b1;
        ticks(3);
        do_sof();
        chk("midrst_died", 32'(alien_died),    32'd0);
        chk("midrst_fire", 32'(colision_fire), 32'd0);
        tick();

        // Falling gold 1 kills.
        player_awake           = 1'b1;
        drawing_request_player = 1'b1;
        gold_dr                = 4'b0010;
        gold_state             = 16'h0020;
        ticks(3);
        clear_overlaps();
        gold_state = 16'h0000;
        do_sof();
        chk("fall_pd",  32'(player_died),     32'd1);
        chk("fall_eat", 32'(player_eat_gold), 32'd0);
        tick();
        chk("fall_inv", 32'(invulnerable),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
